// File: rtl/timer_bank.sv
// Multi-channel down-counter timer bank sharing one prescaler.
// Word-addressed register slave: combinational read, synchronous write.
// Channel n lives at byte offset 16*n; PRESC and IRQ_STAT follow the channels.
module timer_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              irq_o,
  output logic [NUM_CH-1:0] expired_o
);

  localparam int G_WORD = 4 * NUM_CH;

  logic [NUM_CH-1:0]  en_q, mode_q, ie_q, exp_q;
  logic [NUM_CH-1:0]  en_d, mode_d, ie_d, exp_d, fire;
  logic [CNT_W-1:0]   load_q [NUM_CH];
  logic [CNT_W-1:0]   count_q [NUM_CH];
  logic [CNT_W-1:0]   load_d [NUM_CH];
  logic [CNT_W-1:0]   count_d [NUM_CH];
  logic [PRESC_W-1:0] presc_q, pcnt_q;
  logic               tick;

  logic [NUM_CH-1:0]  ch_sel, wr_ctrl, wr_load, wr_count, wr_stat;
  logic               g_presc_sel, g_irq_sel;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];
  assign g_presc_sel = (addr_i[ADDR_W-1:2] == (ADDR_W-2)'(G_WORD));
  assign g_irq_sel   = (addr_i[ADDR_W-1:2] == (ADDR_W-2)'(G_WORD + 1));
  assign tick        = (pcnt_q == presc_q);
  assign irq_o       = |(exp_q & ie_q);

  // Address decode: which channel register, if any, this access targets.
  always_comb begin
    ch_sel   = '0;
    wr_ctrl  = '0;
    wr_load  = '0;
    wr_count = '0;
    wr_stat  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_sel[n] = (addr_i[ADDR_W-1:4] == (ADDR_W-4)'(n));
      if (we_i && ch_sel[n]) begin
        case (addr_i[3:2])
          2'd0:    wr_ctrl[n]  = 1'b1;
          2'd1:    wr_load[n]  = 1'b1;
          2'd2:    wr_count[n] = 1'b1;
          default: wr_stat[n]  = 1'b1;
        endcase
      end
    end
  end

  // Prescaler: free-running counter that wraps on PRESC, restarted by a PRESC write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else if (we_i && g_presc_sel) begin
      presc_q <= data_i[PRESC_W-1:0];
      pcnt_q  <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + PRESC_W'(1);
    end
  end

  // Channel next state: tick countdown first, then software writes override.
  always_comb begin
    en_d    = en_q;
    mode_d  = mode_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    fire    = '0;
    load_d  = load_q;
    count_d = count_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (en_q[n] && tick && (count_q[n] != '0) && !wr_count[n]) begin
        if (count_q[n] == CNT_W'(1)) begin
          fire[n]  = 1'b1;
          exp_d[n] = 1'b1;
          if (mode_q[n]) begin
            count_d[n] = load_q[n];
          end else begin
            count_d[n] = '0;
            en_d[n]    = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] - CNT_W'(1);
        end
      end
      if (wr_count[n]) count_d[n] = data_i[CNT_W-1:0];
      if (wr_load[n])  load_d[n]  = data_i[CNT_W-1:0];
      // A hardware expiry in the same cycle beats the software clear.
      if (wr_stat[n] && data_i[0] && !fire[n]) exp_d[n] = 1'b0;
      if (wr_ctrl[n]) begin
        en_d[n]   = data_i[0];
        mode_d[n] = data_i[1];
        ie_d[n]   = data_i[2];
        if (data_i[0] && !en_q[n]) count_d[n] = load_q[n];
      end
    end
  end

  // Channel state registers and the one-cycle expiry pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q      <= '0;
      mode_q    <= '0;
      ie_q      <= '0;
      exp_q     <= '0;
      expired_o <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        load_q[n]  <= '0;
        count_q[n] <= '0;
      end
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      ie_q      <= ie_d;
      exp_q     <= exp_d;
      expired_o <= fire;
      for (int n = 0; n < NUM_CH; n++) begin
        load_q[n]  <= load_d[n];
        count_q[n] <= count_d[n];
      end
    end
  end

  // Read mux: zero-extended fields, unmapped offsets read zero.
  always_comb begin
    data_o = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel[n]) begin
        case (addr_i[3:2])
          2'd0:    data_o = {29'b0, ie_q[n], mode_q[n], en_q[n]};
          2'd1:    data_o = 32'(load_q[n]);
          2'd2:    data_o = 32'(count_q[n]);
          default: data_o = {31'b0, exp_q[n]};
        endcase
      end
    end
    if (g_presc_sel) data_o = 32'(presc_q);
    if (g_irq_sel)   data_o = 32'(exp_q & ie_q);
  end

endmodule

// File: tb/tb_timer_bank.sv
// Randomized and directed bench for timer_bank against a register-level model.
module tb_timer_bank;

  localparam int NC = 8;
  localparam int CW = 16;
  localparam int PW = 16;
  localparam int AW = 8;
  localparam int G  = 16 * NC;
  localparam int unsigned CMASK = (32'd1 << CW) - 1;
  localparam int unsigned PMASK = (32'd1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq;
  logic [NC-1:0] expired;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_cnt [NC];

  // Reference model state
  bit          m_en [NC];
  bit          m_mode [NC];
  bit          m_ie [NC];
  bit          m_exp [NC];
  int unsigned m_load [NC];
  int unsigned m_count [NC];
  int unsigned m_presc, m_pcnt;
  bit [NC-1:0] m_fired;

  always #5 clk = ~clk;

  timer_bank #(.NUM_CH(NC), .CNT_W(CW), .PRESC_W(PW), .ADDR_W(AW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .addr_i    (addr),
    .we_i      (we),
    .data_i    (wdata),
    .data_o    (rdata),
    .irq_o     (irq),
    .expired_o (expired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int n = 0; n < NC; n++) begin
      m_en[n] = 0; m_mode[n] = 0; m_ie[n] = 0; m_exp[n] = 0;
      m_load[n] = 0; m_count[n] = 0;
    end
    m_presc = 0; m_pcnt = 0; m_fired = '0;
  endfunction

  function automatic int unsigned m_irq_stat();
    int unsigned r = 0;
    for (int n = 0; n < NC; n++) if (m_exp[n] && m_ie[n]) r |= (32'd1 << n);
    return r;
  endfunction

  function automatic int unsigned m_read(input int a);
    int aw = a & 'hFC;
    int n  = aw / 16;
    if (aw < G) begin
      case ((aw % 16) / 4)
        0: return (int'(m_ie[n]) << 2) | (int'(m_mode[n]) << 1) | int'(m_en[n]);
        1: return m_load[n];
        2: return m_count[n];
        default: return int'(m_exp[n]);
      endcase
    end
    if (aw == G)     return m_presc;
    if (aw == G + 4) return m_irq_stat();
    return 0;
  endfunction

  // One clock edge of the model, following the register-map rules.
  function automatic void m_step(input bit w, input int a, input int unsigned d);
    int  aw   = a & 'hFC;
    bit  tick = (m_pcnt == m_presc);
    int  base;
    bit  en_old;
    int unsigned load_old;
    if (w && aw == G) begin
      m_presc = d & PMASK;
      m_pcnt  = 0;
    end else if (tick) begin
      m_pcnt = 0;
    end else begin
      m_pcnt = (m_pcnt + 1) & PMASK;
    end
    m_fired = '0;
    for (int n = 0; n < NC; n++) begin
      base     = 16 * n;
      en_old   = m_en[n];
      load_old = m_load[n];
      if (w && aw == base + 8) begin
        m_count[n] = d & CMASK;
      end else if (en_old && tick && m_count[n] != 0) begin
        if (m_count[n] > 1) begin
          m_count[n] = m_count[n] - 1;
        end else begin
          m_fired[n] = 1'b1;
          m_exp[n]   = 1'b1;
          m_count[n] = m_mode[n] ? load_old : 0;
          if (!m_mode[n]) m_en[n] = 0;
        end
      end
      if (w && aw == base + 4) m_load[n] = d & CMASK;
      if (w && aw == base + 12 && d[0] && !m_fired[n]) m_exp[n] = 0;
      if (w && aw == base) begin
        if (d[0] && !en_old) m_count[n] = load_old;
        m_en[n]   = d[0];
        m_mode[n] = d[1];
        m_ie[n]   = d[2];
      end
    end
  endfunction

  // Drive one cycle, advance the model, and compare all outputs after the edge.
  task automatic cyc(input bit w, input int a, input int unsigned d);
    we = w; addr = AW'(a); wdata = d;
    @(posedge clk);
    m_step(w, a, d);
    #1;
    for (int n = 0; n < NC; n++) if (expired[n]) pulse_cnt[n]++;
    check("expired", 32'(expired), 32'(m_fired));
    check("irq", 32'(irq), 32'(m_irq_stat() != 0));
    check("rdata", rdata, m_read(a));
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int a, input int unsigned exp);
    addr = AW'(a);
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic clr_pulses();
    for (int n = 0; n < NC; n++) pulse_cnt[n] = 0;
  endtask

  task automatic rand_cycle();
    int r  = $urandom_range(0, 9);
    int ch = $urandom_range(0, NC - 1);
    int rf = $urandom_range(0, 3);
    int unsigned d;
    if (r < 4) begin
      cyc(0, $urandom_range(0, 255), $urandom);
    end else if (r == 9) begin
      if ($urandom_range(0, 1) == 1) cyc(1, G | $urandom_range(0, 3), $urandom_range(0, 3));
      else cyc(1, $urandom_range(G + 8, 255), $urandom);
    end else begin
      case (rf)
        0: d = ($urandom & 32'hFFFF_FFF8) | $urandom_range(0, 7);
        1, 2: d = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      cyc(1, 16 * ch + 4 * rf + $urandom_range(0, 3), d);
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    m_reset();
    clr_pulses();
    #12;
    for (int a = 0; a < 256; a++) rd_chk("reset_read", a, 0);
    check("reset_irq", 32'(irq), 0);
    check("reset_expired", 32'(expired), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Periodic ch0, LOAD=5, every-cycle tick
    cyc(1, G, 0);
    cyc(1, 4, 5);
    cyc(1, 0, 7);
    rd_chk("per_count_start", 8, 5);
    clr_pulses();
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 8, 0);
      check("per_count_seq", rdata, 5 - (i % 5));
      check("per_irq_rise", 32'(irq), 32'(i >= 5));
    end
    check("per_pulses", pulse_cnt[0], 2);
    cyc(1, 0, 0);
    cyc(1, 12, 1);
    rd_chk("ch0_cleared", 12, 0);

    // One-shot ch1, PRESC=3, LOAD=2
    cyc(1, G, 3);
    cyc(1, 20, 2);
    clr_pulses();
    cyc(1, 16, 5);
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      cyc(0, 24, 0);
      if (expired[1]) lat = i;
    end
    check("oneshot_latency", lat, 6);
    for (int i = 0; i < 20; i++) cyc(0, 24, 0);
    check("oneshot_pulses", pulse_cnt[1], 1);
    rd_chk("oneshot_ctrl", 16, 4);
    rd_chk("oneshot_count", 24, 0);
    rd_chk("oneshot_exp", 28, 1);
    check("oneshot_irq", 32'(irq), 1);

    // W1C and its collision with a hardware expiry
    cyc(1, 28, 1);
    check("w1c_irq_drop", 32'(irq), 0);
    cyc(1, G, 0);
    cyc(1, 36, 1);
    cyc(1, 32, 3);
    cyc(0, 44, 0);
    clr_pulses();
    cyc(1, 44, 1);
    rd_chk("w1c_vs_set", 44, 1);
    for (int i = 0; i < 4; i++) cyc(0, 44, 0);
    check("load1_every_tick", pulse_cnt[2], 5);
    cyc(1, 32, 0);
    cyc(1, 44, 1);
    rd_chk("ch2_cleared", 44, 0);

    // COUNT write colliding with a tick; LOAD=0 idles
    cyc(1, 52, 100);
    cyc(1, 48, 1);
    cyc(0, 56, 0);
    cyc(1, 56, 10);
    rd_chk("count_write_wins", 56, 10);
    cyc(1, 64, 7);
    clr_pulses();
    for (int i = 0; i < 1000; i++) cyc(0, $urandom_range(0, 255), 0);
    check("load0_no_expiry", pulse_cnt[4], 0);
    rd_chk("load0_status", 76, 0);
    check("ch3_oneshot_once", pulse_cnt[3], 1);

    // Narrow field truncation and IRQ_STAT
    cyc(1, 84, 32'h12345);
    rd_chk("load_trunc", 84, 32'h2345);
    rd_chk("irq_stat", G + 4, m_irq_stat());

    for (int i = 0; i < 3000; i++) rand_cycle();

    // Asynchronous reset mid-count
    cyc(1, G, 0);
    cyc(1, 100, 7);
    cyc(1, 96, 7);
    cyc(0, 104, 0);
    cyc(0, 104, 0);
    #2;
    rst_n = 1'b0;
    m_reset();
    rd_chk("async_count", 104, 0);
    check("async_irq", 32'(irq), 0);
    check("async_expired", 32'(expired), 0);
    for (int a = 0; a < G + 8; a += 4) rd_chk("async_read", a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_pulses();
    for (int i = 0; i < 10; i++) cyc(0, 104, 0);
    check("post_reset_no_pulse", pulse_cnt[6], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
